dlx_execute_stage: RTL
======================

# dlx_execute_stage

Execute stage of the DLX pipeline. Consumes the stage-2 bundle driven by the decode stage (`aluin1`, `aluin2`, `operation`, `opselect`, `shift_number`, `enable_arith`, `enable_shift`) and produces a registered 32-bit result with carry, overflow and zero flags. The block is a two-deep registered pipeline: operand capture, then compute and result register. A global `stall` freezes both stages.

## Interface

Parameters:
- `WIDTH`, 32: datapath width. The spec and tests assume 32.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `aluin1` in 32: operand A; also the shift source.
- `aluin2` in 32: operand B.
- `operation` in 3: op code within the selected unit.
- `opselect` in 3: `3'b001` selects the arithmetic/logic unit, `3'b000` the shifter, other values are a NOP.
- `shift_number` in 5: shift amount, 0–31.
- `enable_arith` in 1: issue an arithmetic/logic op this cycle.
- `enable_shift` in 1: issue a shift op this cycle.
- `stall` in 1: hold every register.
- `aluout` out 32: result.
- `carry` out 1: carry, borrow or last bit shifted out.
- `overflow` out 1: signed overflow.
- `zero` out 1: `aluout == 0`.
- `out_valid` out 1: result and flags are valid this cycle.
- `conflict` out 1: sticky error flag; both enables were seen high.

## Operation

- **Issue.** An op is issued when `stall` = 0, (`enable_arith` | `enable_shift`) = 1 and `opselect` is `000` or `001`.
- **Stage A.** Registers all bundle fields plus an internal `a_valid`.
- **Stage B.** Computes from the stage A registers and loads `aluout`, `carry`, `overflow`, `zero` and `out_valid` = `a_valid`.
- **Enable pairing.** Arithmetic requires `opselect` = `001` with `enable_arith`; shift requires `opselect` = `000` with `enable_shift`. Any mismatch is a NOP: `a_valid` = 0.
- **Both enables high.** The op is treated as the `opselect` unit, and `conflict` is set. `conflict` is cleared only by reset.
- **Arithmetic ops (`operation`):**
  - `000` ADD: uses a 33-bit sum. `carry` = bit 32; `overflow` = operand signs equal and result sign differs.
  - `001` SUB (A−B): `carry` = borrow (A < B unsigned); `overflow` = operand signs differ and result sign ≠ sign of A.
  - `010` AND, `011` OR, `100` XOR, `101` NOT A, `111` pass B.
  - `110` SLT signed: result is 1 or 0.
  - Every op except ADD and SUB drives `carry` = `overflow` = 0.
- **Shift ops (`operation`), data = `aluin1`, amount n = `shift_number`:**
  - `000` SLL: `carry` = bit (32−n).
  - `001` SRL: `carry` = bit (n−1).
  - `010` SRA: `carry` = bit (n−1).
  - `011` ROL, `1xx` ROR: `carry` = 0.
  - n = 0: result = A, `carry` = 0 for every shift.
  - `overflow` is always 0 for shifts.
- **Result hold.** When `out_valid` = 0, `aluout` and the flags hold their last values; only `out_valid` drops.

## Timing

- **Reset** (`rst` low, asynchronous): `aluout` = 0, `carry` = 0, `overflow` = 0, `zero` = 1, `out_valid` = 0, `conflict` = 0. All stage A registers including `a_valid` = 0.
- **Reset mid-operation:** in-flight ops are discarded, with no output after release.
- **Latency:** inputs sampled at edge N produce `out_valid` = 1 and the result from edge N+1. Throughput is one op per cycle.
- **Stall:** while `stall` = 1, both stages hold and outputs are frozen, including `out_valid`.
  - Enables presented during stall are ignored. Upstream must re-present the op after stall drops.
  - Stall rising at the same edge as an issue: the issue is dropped.
- **Back-to-back ops:** each op produces its own one-cycle `out_valid` pulse on consecutive cycles.

## Test plan

- **Reset:** hold `rst` = 0 for 3 cycles with random inputs → all outputs at reset values, `zero` = 1, no `out_valid`.
- **ADD overflow:** ADD `7FFFFFFF` + `00000001` → at N+1 `aluout` = `80000000`, `overflow` = 1, `carry` = 0, `out_valid` pulses one cycle.
- **SUB borrow and SLT:** SUB `00000003` − `00000005` → `FFFFFFFE`, `carry` = 1. Then SLT `FFFFFFFF` vs `00000001` → 1.
- **Shifts:** SRA `80000001` by 1 → `C0000000`, `carry` = 1. SLL by 0 → result = A, `carry` = 0. ROR `00000001` by 1 → `80000000`.
- **Stall:** issue three back-to-back ops and assert `stall` for 2 cycles during the second → outputs frozen; the op presented during stall produces no result.
- **Conflict / NOP:** both enables high with `opselect` = `001` → arithmetic result produced, `conflict` = 1 until reset. `opselect` = `010` with `enable_arith` → no `out_valid`.

Source files
------------

// File: rtl/dlx_execute_stage_if.sv
// Stage-2 bundle from decode into execute, plus the execute result/flags.
// master = decode side, slave = execute stage.
interface dlx_execute_stage_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] aluin1;
  logic [WIDTH-1:0] aluin2;
  logic [2:0]       operation;
  logic [2:0]       opselect;
  logic [4:0]       shift_number;
  logic             enable_arith;
  logic             enable_shift;
  logic             stall;
  logic [WIDTH-1:0] aluout;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             out_valid;
  logic             conflict;

  modport master (
    output aluin1, aluin2, operation, opselect,
    output shift_number, enable_arith, enable_shift,
    output stall,
    input  aluout, carry, overflow, zero,
    input  out_valid, conflict
  );

  modport slave (
    input  aluin1, aluin2, operation, opselect,
    input  shift_number, enable_arith, enable_shift,
    input  stall,
    output aluout, carry, overflow, zero,
    output out_valid, conflict
  );
endinterface

// File: rtl/dlx_execute_stage.sv
// DLX execute stage: operand capture register, then ALU/shifter
// and result register. A global stall freezes both stages.
module dlx_execute_stage #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  dlx_execute_stage_if.slave  bus
);

  logic [WIDTH-1:0] a_in1;
  logic [WIDTH-1:0] a_in2;
  logic [2:0]       a_op;
  logic [4:0]       a_amt;
  logic             a_shift;
  logic             a_valid;

  logic             arith_go;
  logic             shift_go;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [4:0]       neg_amt;
  logic [4:0]       lo_idx;
  logic             slt;

  // A unit only fires when its enable matches opselect
  assign arith_go = (bus.opselect == 3'b001) && bus.enable_arith;
  assign shift_go = (bus.opselect == 3'b000) && bus.enable_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_in1   <= '0;
      a_in2   <= '0;
      a_op    <= '0;
      a_amt   <= '0;
      a_shift <= 1'b0;
      a_valid <= 1'b0;
    end else if (!bus.stall) begin
      a_in1   <= bus.aluin1;
      a_in2   <= bus.aluin2;
      a_op    <= bus.operation;
      a_amt   <= bus.shift_number;
      a_shift <= (bus.opselect == 3'b000);
      a_valid <= arith_go | shift_go;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.conflict <= 1'b0;
    end else if (!bus.stall
                 && bus.enable_arith
                 && bus.enable_shift) begin
      bus.conflict <= 1'b1;
    end
  end

  assign sum     = {1'b0, a_in1} + {1'b0, a_in2};
  assign dif     = {1'b0, a_in1} - {1'b0, a_in2};
  assign neg_amt = 5'd0 - a_amt;
  assign lo_idx  = a_amt - 5'd1;
  assign slt     = $signed(a_in1) < $signed(a_in2);

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (a_shift) begin
      if (a_amt == 5'd0) begin
        res = a_in1;
      end else begin
        unique case (1'b1)
          a_op == 3'b000: begin
            res   = a_in1 << a_amt;
            res_c = a_in1[neg_amt];
          end
          a_op == 3'b001: begin
            res   = a_in1 >> a_amt;
            res_c = a_in1[lo_idx];
          end
          a_op == 3'b010: begin
            res   = $signed(a_in1) >>> a_amt;
            res_c = a_in1[lo_idx];
          end
          a_op == 3'b011: begin
            res = (a_in1 << a_amt)
                | (a_in1 >> neg_amt);
          end
          a_op[2]: begin
            res = (a_in1 >> a_amt)
                | (a_in1 << neg_amt);
          end
        endcase
      end
    end else begin
      unique case (1'b1)
        a_op == 3'b000: begin
          res   = sum[WIDTH-1:0];
          res_c = sum[WIDTH];
          res_v = (a_in1[WIDTH-1] == a_in2[WIDTH-1])
               && (sum[WIDTH-1] != a_in1[WIDTH-1]);
        end
        a_op == 3'b001: begin
          res   = dif[WIDTH-1:0];
          res_c = dif[WIDTH];
          res_v = (a_in1[WIDTH-1] != a_in2[WIDTH-1])
               && (dif[WIDTH-1] != a_in1[WIDTH-1]);
        end
        a_op == 3'b010: res = a_in1 & a_in2;
        a_op == 3'b011: res = a_in1 | a_in2;
        a_op == 3'b100: res = a_in1 ^ a_in2;
        a_op == 3'b101: res = ~a_in1;
        a_op == 3'b110: res = {{(WIDTH-1){1'b0}}, slt};
        a_op == 3'b111: res = a_in2;
      endcase
    end
  end

  // Result and flags only move on a valid op; out_valid alone drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.aluout    <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid <= a_valid;
      if (a_valid) begin
        bus.aluout   <= res;
        bus.carry    <= res_c;
        bus.overflow <= res_v;
        bus.zero     <= (res == '0);
      end
    end
  end

endmodule
